// File: rtl/fwd_pkg.sv
// fwd_pkg: select encodings, tracking-slot layout and slot match helper for the forwarding controller
package fwd_pkg;
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;
  typedef struct packed {
    logic       v;
    logic       wr;
    logic [1:0] rd;
    logic       ld;
  } slot_t;
  function automatic logic writes(input slot_t s, input logic [1:0] r);
    return s.v & s.wr & (s.rd == r);
  endfunction
endpackage

// File: rtl/fwd_match.sv
// fwd_match: priority operand select for one source register, youngest producer first
module fwd_match
  import fwd_pkg::*;
(
  input  logic [1:0] rs,
  input  logic       use_r,
  input  slot_t      ex,
  input  slot_t      mem,
  input  slot_t      wb,
  output logic [1:0] sel
);
  always_comb
    sel = !use_r          ? SEL_RF  :
          writes(ex, rs)  ? SEL_EXM :
          writes(mem, rs) ? SEL_MWB :
          writes(wb, rs)  ? SEL_WB  : SEL_RF;
endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: EX/MEM/WB destination tracking, registered forwarding selects and load-use stall
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [1:0]       id_rs_a,
  input  logic [1:0]       id_rs_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic             id_wr_en,
  input  logic [1:0]       id_rd,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic             sel_a_s0,
  output logic             sel_a_s1,
  output logic             sel_b_s0,
  output logic             sel_b_s1,
  output logic [CNT_W-1:0] stall_cnt
);
  slot_t ex_q, mem_q, wb_q, ex_d;
  logic [1:0] sel_a_q, sel_b_q, sel_a_d, sel_b_d, sel_a_m, sel_b_m;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic kill;
  fwd_match u_match_a (.rs(id_rs_a), .use_r(id_use_a), .ex(ex_q), .mem(mem_q), .wb(wb_q), .sel(sel_a_m));
  fwd_match u_match_b (.rs(id_rs_b), .use_r(id_use_b), .ex(ex_q), .mem(mem_q), .wb(wb_q), .sel(sel_b_m));
  always_comb begin
    stall = id_valid & ~flush & ex_q.v & ex_q.wr & ex_q.ld &
            ((id_use_a & (ex_q.rd == id_rs_a)) | (id_use_b & (ex_q.rd == id_rs_b)));
    kill = flush | stall | ~id_valid;
    ex_d = (flush | stall) ? '0 : '{v: id_valid, wr: id_wr_en, rd: id_rd, ld: id_is_load};
    sel_a_d = kill ? SEL_RF : sel_a_m;
    sel_b_d = kill ? SEL_RF : sel_b_m;
    stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  assign {sel_a_s1, sel_a_s0} = sel_a_q;
  assign {sel_b_s1, sel_b_s0} = sel_b_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed forwarding, load-use stall, flush, reset and saturation checks
module tb_fwd_ctrl;
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n;
  logic id_valid, id_use_a, id_use_b, id_wr_en, id_is_load, flush;
  logic [1:0] id_rs_a, id_rs_b, id_rd;
  logic stall, sel_a_s0, sel_a_s1, sel_b_s0, sel_b_s1;
  logic [7:0] stall_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int n_stall;
  logic st;
  always #5 if (clk_en) clk = ~clk;
  fwd_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_is_load(id_is_load), .flush(flush), .stall(stall), .sel_a_s0(sel_a_s0),
    .sel_a_s1(sel_a_s1), .sel_b_s0(sel_b_s0), .sel_b_s1(sel_b_s1), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [1:0] ra, input logic [1:0] rb, input logic ua,
                      input logic ub, input logic wr, input logic [1:0] rd, input logic ld,
                      input logic fl, output logic s);
    {id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b} = {v, ra, rb, ua, ub};
    {id_wr_en, id_rd, id_is_load, flush} = {wr, rd, ld, fl};
    #1 s = stall;
    @(posedge clk);
    #1;
  endtask
  task automatic nop();
    logic s;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, s);
  endtask
  task automatic chk_sel(input string tag, input int a, input int b);
    chk({tag, "_a"}, {sel_a_s1, sel_a_s0}, a);
    chk({tag, "_b"}, {sel_b_s1, sel_b_s0}, b);
  endtask
  initial begin
    rst_n = 1'b1;
    {id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b, id_wr_en, id_rd, id_is_load, flush} = '0;
    #3 rst_n = 1'b0;
    #1;
    chk_sel("rst_sel", 0, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", stall_cnt, 0);
    clk_en = 1'b1;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) nop();
    // EX forward of R1 to A; B reads R1 but unused
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, st);
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, st);
    chk_sel("ex_fwd", 1, 0);
    // producer R2 with 1, 2, 3 unrelated gaps, consumer on B
    for (int g = 1; g <= 3; g++) begin
      step(1, 0, 0, 0, 0, 1, 2, 0, 0, st);
      repeat (g) step(1, 0, 0, 0, 0, 0, 0, 0, 0, st);
      step(1, 0, 2, 0, 1, 0, 0, 0, 0, st);
      chk_sel($sformatf("gap%0d", g), 0, g == 1 ? 2 : g == 2 ? 3 : 0);
    end
    // load-use R3 on A
    step(1, 0, 0, 0, 0, 1, 3, 1, 0, st);
    chk("lu_nostall_load", st, 0);
    step(1, 3, 0, 1, 0, 0, 0, 0, 0, st);
    chk("lu_stall", st, 1);
    chk_sel("lu_bubble", 0, 0);
    chk("lu_cnt", stall_cnt, 1);
    step(1, 3, 0, 1, 0, 0, 0, 0, 0, st);
    chk("lu_release", st, 0);
    chk_sel("lu_fwd", 2, 0);
    chk("lu_cnt_hold", stall_cnt, 1);
    // same pair with flush in the hazard cycle; flushed consumer would write R0
    step(1, 0, 0, 0, 0, 1, 3, 1, 0, st);
    step(1, 3, 0, 1, 0, 1, 0, 0, 1, st);
    chk("fl_stall", st, 0);
    chk_sel("fl_sel", 0, 0);
    chk("fl_cnt", stall_cnt, 1);
    step(1, 0, 3, 1, 1, 0, 0, 0, 0, st);
    chk_sel("fl_ex_inv", 0, 2);
    // two R0 producers, youngest wins on both operands
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, st);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, st);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, st);
    chk_sel("young", 1, 1);
    // reset mid-operation with the clock frozen
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_sel("mid_rst_sel", 0, 0);
    chk("mid_rst_cnt", stall_cnt, 0);
    chk("mid_rst_stall", stall, 0);
    #2 rst_n = 1'b1;
    #2 clk_en = 1'b1;
    @(posedge clk);
    #1;
    // self-dependent load R1 held in ID: stalls every other cycle
    n_stall = 0;
    for (int i = 1; i <= 600; i++) begin
      step(1, 1, 0, 1, 0, 1, 1, 1, 0, st);
      n_stall += int'(st);
      if (i == 200) chk("sat_mid", stall_cnt, 100);
    end
    chk("sat_stalls", n_stall, 300);
    chk("sat_cnt", stall_cnt, 255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Forwarding and load-use hazard controller for the 8-bit pipeline. It records the destination register of every instruction issued from ID, tracking it through the EX, MEM and WB slots. For each issued instruction it produces the registered 2-bit select pairs ({s1,s0}) that steer the 4:1 operand muxes in EX. It also detects load-use hazards, stalls ID for one cycle and inserts a bubble.

## Interface
Parameters:
- CNT_W, 8, width of the saturating stall-event counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs_a  in  2  source register of operand A (R0–R3).
- id_rs_b  in  2  source register of operand B.
- id_use_a  in  1  operand A is read.
- id_use_b  in  1  operand B is read.
- id_wr_en  in  1  instruction writes a register.
- id_rd  in  2  destination register.
- id_is_load  in  1  result comes from memory, available only after MEM.
- flush  in  1  branch/interrupt flush; kills the ID instruction this cycle.
- stall  out  1  combinational; holds PC and IF/ID, forces a bubble into EX.
- sel_a_s0, sel_a_s1  out  1 each  operand-A mux select for the instruction now in EX.
- sel_b_s0, sel_b_s1  out  1 each  operand-B mux select.
- stall_cnt  out  CNT_W  count of load-use stalls since reset, saturating.

## Operation
- Select encoding {s1,s0}:
  - 00: register file.
  - 01: EX/MEM ALU result.
  - 10: MEM/WB result.
  - 11: WB write-data hold register.
- Each tracking slot (EX, MEM, WB) holds {v, wr, rd, ld}. A slot "writes r" when v & wr & rd==r.
- Hazard, combinational: stall = id_valid & ~flush & EX.v & EX.wr & EX.ld & ((id_use_a & EX.rd==id_rs_a) | (id_use_b & EX.rd==id_rs_b)).
- Select per used operand, youngest producer first:
  - EX slot writes rs (non-load, since loads stall): 01.
  - else MEM slot writes rs: 10.
  - else WB slot writes rs: 11.
  - else 00.
- Unused operand: 00.
- Every rising edge, slots shift WB←MEM, MEM←EX. The new EX slot takes:
  - flush: v=0, selects 00.
  - stall: v=0, selects 00 (bubble).
  - else: {id_valid, id_wr_en, id_rd, id_is_load}, with the computed selects registered.
- An invalid EX entry (id_valid=0) carries selects 00.
- stall_cnt increments on each edge where stall=1, holding at 2^CNT_W−1.
- flush and a would-be hazard in the same cycle: flush wins, stall=0, no count.
- All four registers R0–R3 are ordinary; no hardwired-zero register.

## Timing
- Reset (async assert, sync-safe deassert by the system): all slot v=0, all sel outputs 0, stall=0, stall_cnt=0.
- Reset mid-operation discards all tracking immediately, and the outputs drop to reset values without waiting for a clock.
- Select latency: computed in the ID cycle, visible on outputs one edge later, and aligned with the instruction in EX.
- A load-use dependency costs exactly one stall cycle. On the next cycle the load sits in MEM, stall deasserts and the consumer receives select 10.
- stall has no register delay. It depends only on the current inputs and the EX slot.
- Back-to-back loads with chained dependencies each stall once.

## Structure
- Shared package fwd_pkg, holding:
  - select localparams SEL_RF=2'b00, SEL_EXM=2'b01, SEL_MWB=2'b10, SEL_WB=2'b11;
  - the slot field layout (v, wr, rd[1:0], ld).
- Sub-module fwd_match: combinational priority select for one operand, given rs, use and the three slots. It is instantiated twice, for A and B.
- The top holds the slot shift register, the stall logic, the output registers and the counter.

## Test plan
- Reset with clk stopped: assert rst_n=0 → all sel=0, stall=0, stall_cnt=0 asynchronously.
- ALU write R1, then next instruction reads R1 on A → after the second issue edge, {sel_a_s1,sel_a_s0}=01, B=00.
- Producer R2, one unrelated instruction, then consumer reading R2 on B → B select 10. Repeat with two gaps → 11. Repeat with three gaps → 00.
- Load R3, then immediate consumer of R3 on A:
  - stall=1 for exactly one cycle, with EX bubble selects 00 and stall_cnt=1;
  - next edge gives A select 10.
- Same load-use pair with flush=1 in the hazard cycle → stall=0, stall_cnt unchanged, EX v=0.
- Two producers of R0 in EX and MEM, consumer reads R0 on both operands → both selects 01 (youngest wins).
- 300 consecutive load-use pairs → stall_cnt saturates at 255.
